// File: rtl/blob_pkg.sv
// Shared constants and types for the compressed-struct ESI receive path.
// Includes the channel message layout and the unpacker FSM state encoding.
package blob_pkg;

  localparam int BLOB_W     = 256;
  localparam int CHUNK_W    = 8;
  localparam int LEVEL_W    = 4;
  localparam int NUM_CHUNKS = BLOB_W / CHUNK_W;

  localparam logic [CHUNK_W-1:0] KEY = 8'hA5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Field order matches the channel struct: encrypted is the MSB.
  typedef struct packed {
    logic               encrypted;
    logic [LEVEL_W-1:0] compressionLevel;
    logic [BLOB_W-1:0]  blob;
  } compressed_t;

endpackage

// File: rtl/blob_unpacker.sv
// Serializes one compressed-struct message into CHUNK_W-bit words, LSB chunk first.
// Define BLOB_UNPACKER_DISPLAY_EN to print each accepted message and each emitted chunk.
module blob_unpacker
  import blob_pkg::*;
#(
  parameter int                 BLOB_W  = blob_pkg::BLOB_W,
  parameter int                 CHUNK_W = blob_pkg::CHUNK_W,
  parameter int                 LEVEL_W = blob_pkg::LEVEL_W,
  parameter logic [CHUNK_W-1:0] KEY     = blob_pkg::KEY
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_encrypted,
  input  logic [LEVEL_W-1:0] in_level,
  input  logic [BLOB_W-1:0]  in_blob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_last,
  output logic [15:0]        msg_count,
  output logic [31:0]        chunk_count
);

  localparam int N_CHUNKS = BLOB_W / CHUNK_W;
  localparam int IDX_W    = $clog2(N_CHUNKS);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]         state;
  logic [BLOB_W-1:0]  shreg;
  logic [IDX_W-1:0]   idx;
  logic               enc_q;
  logic [LEVEL_W-1:0] lvl_q;
  logic               accept;
  logic               fire;
  logic               rest_zero;

  assign in_ready  = rstn && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_SEND);
  assign fire      = out_valid && out_ready;
  assign out_data  = shreg[CHUNK_W-1:0] ^ (enc_q ? KEY : '0);

  // A non-zero level ends the message early once everything above this chunk is zero.
  assign rest_zero = ((shreg >> CHUNK_W) == '0);
  assign out_last  = out_valid &&
                     ((idx == IDX_W'(N_CHUNKS - 1)) || ((lvl_q != '0) && rest_zero));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      idx         <= '0;
      enc_q       <= 1'b0;
      lvl_q       <= '0;
      msg_count   <= '0;
      chunk_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= in_blob;
            enc_q <= in_encrypted;
            lvl_q <= in_level;
            idx   <= '0;
            state <= ST_SEND;
          end
        end
        default: begin
          if (fire) begin
            chunk_count <= chunk_count + 32'd1;
            if (out_last) begin
              msg_count <= msg_count + 16'd1;
              state     <= ST_IDLE;
            end else begin
              shreg <= shreg >> CHUNK_W;
              idx   <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef BLOB_UNPACKER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (rstn && fire) begin
      $display("Chunk: %3d Data: %h Last: %b", idx, out_data, out_last);
    end
    if (accept) begin
      $display("Msg: enc=%b lvl=%0d", in_encrypted, in_level);
    end
  end
`else
  // Silent build: no simulation messages.
`endif

endmodule

// File: tb/tb_blob_unpacker.sv
// Directed self-checking bench for blob_unpacker: latency, early termination,
// backpressure stability, mid-message reset and back-to-back message spacing.
module tb_blob_unpacker;
  import blob_pkg::*;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic               in_ready;
  logic               in_encrypted;
  logic [LEVEL_W-1:0] in_level;
  logic [BLOB_W-1:0]  in_blob;
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK_W-1:0] out_data;
  logic               out_last;
  logic [15:0]        msg_count;
  logic [31:0]        chunk_count;

  int checks;
  int failures;
  int msgs;
  int chunks;

  blob_unpacker dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_encrypted (in_encrypted),
    .in_level     (in_level),
    .in_blob      (in_blob),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .msg_count    (msg_count),
    .chunk_count  (chunk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_msg_count", 64'(msg_count), 64'd0);
    checkOutput("rst_chunk_count", 64'(chunk_count), 64'd0);
    rstn = 1'b1;
    msgs = 0;
    chunks = 0;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Present a message from a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input compressed_t msg, input bit hold);
    in_encrypted = msg.encrypted;
    in_level     = msg.compressionLevel;
    in_blob      = msg.blob;
    in_valid     = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (in_ready) begin
      @(negedge clk);
    end else begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Walk the expected chunk stream; optional ~25% stall pattern; stop after max_n handshakes.
  task automatic receiveMessage(input compressed_t msg, input bit stall, input int max_n);
    logic [BLOB_W-1:0]  rest;
    logic [CHUNK_W-1:0] exp_data;
    logic               exp_last;
    int                 i;
    int                 cyc;
    bit                 done;
    i    = 0;
    cyc  = 0;
    done = 0;
    while (!done && i < max_n && cyc < 400) begin
      out_ready = (stall && (cyc % 4 == 1)) ? 1'b0 : 1'b1;
      exp_data  = msg.blob[CHUNK_W*i +: CHUNK_W] ^ (msg.encrypted ? 8'hA5 : 8'h00);
      rest      = msg.blob >> (CHUNK_W * (i + 1));
      exp_last  = (i == NUM_CHUNKS - 1) || ((msg.compressionLevel != 0) && (rest == '0));
      checkOutput("out_valid", 64'(out_valid), 64'd1);
      checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
      checkOutput($sformatf("data[%0d]", i), 64'(out_data), 64'(exp_data));
      checkOutput($sformatf("last[%0d]", i), 64'(out_last), 64'(exp_last));
      if (out_ready) begin
        chunks++;
        if (exp_last) begin
          msgs++;
          done = 1;
        end
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (!done && i < max_n) checkOutput("recv_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_msg_count"}, 64'(msg_count), 64'(msgs[15:0]));
    checkOutput({tag, "_chunk_count"}, 64'(chunk_count), 64'(chunks));
  endtask

  compressed_t m;
  compressed_t m2;

  initial begin
    checks       = 0;
    failures     = 0;
    msgs         = 0;
    chunks       = 0;
    rstn         = 1'b0;
    in_valid     = 1'b0;
    in_encrypted = 1'b0;
    in_level     = '0;
    in_blob      = '0;
    out_ready    = 1'b1;
    @(negedge clk);
    doReset();

    // Encrypted, level 6: AA A5 A3 85 then last.
    m = '{encrypted: 1'b1, compressionLevel: 4'd6, blob: 256'h0000002006000F};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b0, 64);
    checkOutput("t1_chunks", 64'(chunks), 64'd4);
    checkCounters("t1");

    // Raw zero blob: all 32 chunks.
    m = '{encrypted: 1'b0, compressionLevel: 4'd0, blob: '0};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b0, 64);
    checkCounters("t2");

    // Compressed zero blob: single chunk, then idle.
    m = '{encrypted: 1'b0, compressionLevel: 4'd3, blob: '0};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b0, 64);
    checkOutput("t3_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t3_out_valid", 64'(out_valid), 64'd0);
    checkCounters("t3");

    // Top byte only, with stalls.
    m = '{encrypted: 1'b0, compressionLevel: 4'd5, blob: {8'hFF, 248'h0}};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b1, 64);
    checkCounters("t4");

    // Mid-message reset after 10 chunks drops the message.
    m = '{encrypted: 1'b0, compressionLevel: 4'd0, blob: {8{32'hDEADBEEF}}};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b0, 10);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_msg_count", 64'(msg_count), 64'd0);
    checkOutput("t5_chunk_count", 64'(chunk_count), 64'd0);
    rstn = 1'b1;
    msgs = 0;
    chunks = 0;
    #1;
    checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    m = '{encrypted: 1'b1, compressionLevel: 4'd0, blob: {8{32'h0BADF00D}}};
    applyStimulus(m, 1'b0);
    receiveMessage(m, 1'b0, 64);
    checkCounters("t5");

    // Back-to-back with in_valid held: one idle bubble between messages.
    doReset();
    m  = '{encrypted: 1'b0, compressionLevel: 4'd1, blob: 256'h12};
    m2 = '{encrypted: 1'b1, compressionLevel: 4'd2, blob: 256'h3456};
    applyStimulus(m, 1'b1);
    in_encrypted = m2.encrypted;
    in_level     = m2.compressionLevel;
    in_blob      = m2.blob;
    receiveMessage(m, 1'b0, 64);
    checkOutput("t6_bubble_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t6_bubble_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    receiveMessage(m2, 1'b0, 64);
    checkOutput("t6_msg_count", 64'(msg_count), 64'd2);
    checkCounters("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
